// File: rtl/card_dealer_if.sv
// Handshake bundle between the card dealer, the 2 kHz counter and the game FSM.
// The dealer connects through the slave modport; its driver connects through master.
interface card_dealer_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] i_Count;
    logic             i_TwoSec;
    logic             i_DrawReq;
    logic             i_NewDeck;
    logic             o_ActCounter;
    logic             o_RstCounter;
    logic [3:0]       o_Card;
    logic             o_CardValid;
    logic             o_Busy;
    logic             o_DeckEmpty;

    modport master (
        output i_Count, i_TwoSec, i_DrawReq, i_NewDeck,
        input  o_ActCounter, o_RstCounter, o_Card, o_CardValid, o_Busy, o_DeckEmpty
    );

    modport slave (
        input  i_Count, i_TwoSec, i_DrawReq, i_NewDeck,
        output o_ActCounter, o_RstCounter, o_Card, o_CardValid, o_Busy, o_DeckEmpty
    );
endinterface

// File: rtl/card_dealer.sv
// Card dealer: seeds a rank from counter xor LFSR, reduces it mod NUM_RANKS, skips exhausted
// ranks, holds the counter for its 2 s display run and then publishes the card.
module card_dealer #(
    parameter int WIDTH     = 12,
    parameter int NUM_RANKS = 13,
    parameter int COPIES    = 4
) (
    input  logic         clk_2K,
    input  logic         i_Reset,
    card_dealer_if.slave bus
);
    localparam int RW   = $clog2(NUM_RANKS + 1);
    localparam int CW   = $clog2(WIDTH);
    localparam int DECK = NUM_RANKS * COPIES;

    typedef enum logic [1:0] {IDLE, DIV, PROBE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    rank_q, rank_d;
    logic [2:0]       tally_q [1:NUM_RANKS];
    logic [2:0]       tally_d [1:NUM_RANKS];
    logic [5:0]       total_q, total_d;
    logic [3:0]       card_q, card_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             empty_q, empty_d;
    logic             act_q, act_d;
    logic             rstc_q, rstc_d;

    logic [RW:0]      trial;
    logic             q_bit;
    logic [RW-1:0]    rem_step;

    // One restoring-division step: bring down the next seed bit, subtract if it fits.
    always_comb begin
        trial    = {rem_q, seed_q[WIDTH-1]};
        q_bit    = (trial >= (RW+1)'(NUM_RANKS));
        rem_step = q_bit ? RW'(trial - (RW+1)'(NUM_RANKS)) : RW'(trial);
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        seed_d  = seed_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        rank_d  = rank_q;
        tally_d = tally_q;
        total_d = total_q;
        card_d  = card_q;
        valid_d = 1'b0;
        act_d   = act_q;
        rstc_d  = rstc_q;

        unique case (state_q)
            IDLE: begin
                act_d  = 1'b0;
                rstc_d = 1'b1;
                if (bus.i_NewDeck) begin
                    for (int i = 1; i <= NUM_RANKS; i++) tally_d[i] = '0;
                    total_d = '0;
                end else if (bus.i_DrawReq && !empty_q) begin
                    seed_d  = bus.i_Count ^ lfsr_q[WIDTH-1:0];
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                seed_d = {seed_q[WIDTH-2:0], q_bit};
                rem_d  = rem_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    rank_d  = rem_step + 1'b1;
                    state_d = PROBE;
                end
            end
            PROBE: begin
                if (tally_q[rank_q] < 3'(COPIES)) begin
                    tally_d[rank_q] = tally_q[rank_q] + 1'b1;
                    total_d         = total_q + 1'b1;
                    act_d           = 1'b1;
                    rstc_d          = 1'b0;
                    state_d         = HOLD;
                end else begin
                    rank_d = (rank_q == RW'(NUM_RANKS)) ? RW'(1) : rank_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.i_TwoSec) begin
                    card_d  = 4'(rank_q);
                    valid_d = 1'b1;
                    act_d   = 1'b0;
                    rstc_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        empty_d = (total_d == 6'(DECK));
    end

    always_ff @(posedge clk_2K or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q <= IDLE;
            lfsr_q  <= 16'hACE1;
            seed_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            rank_q  <= '0;
            for (int i = 1; i <= NUM_RANKS; i++) tally_q[i] <= '0;
            total_q <= '0;
            card_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            empty_q <= 1'b0;
            act_q   <= 1'b0;
            rstc_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            seed_q  <= seed_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            rank_q  <= rank_d;
            for (int i = 1; i <= NUM_RANKS; i++) tally_q[i] <= tally_d[i];
            total_q <= total_d;
            card_q  <= card_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            empty_q <= empty_d;
            act_q   <= act_d;
            rstc_q  <= rstc_d;
        end
    end

    assign bus.o_ActCounter = act_q;
    assign bus.o_RstCounter = rstc_q;
    assign bus.o_Card       = card_q;
    assign bus.o_CardValid  = valid_q;
    assign bus.o_Busy       = busy_q;
    assign bus.o_DeckEmpty  = empty_q;
endmodule

// File: tb/tb_card_dealer.sv
// Randomized bench for card_dealer: a deck model (tallies per rank, modulo arithmetic) predicts
// every dealt card and the request-to-counter-enable latency.
module tb_card_dealer;
    localparam int WIDTH = 12;
    localparam int NR    = 13;
    localparam int CP    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    card_dealer_if #(.WIDTH(WIDTH)) bus();

    card_dealer #(.WIDTH(WIDTH), .NUM_RANKS(NR), .COPIES(CP)) dut (
        .clk_2K  (clk),
        .i_Reset (rst_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference deck state.
    int m_tally [1:NR];
    int m_total;

    // Reference LFSR; m_prev holds the value the DUT used at the most recent edge.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 1; i <= NR; i++) m_tally[i] = 0;
        m_total = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_DrawReq = 1'b0;
        bus.i_NewDeck = 1'b0;
        bus.i_TwoSec  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // Full draw; force_seed >= 0 steers i_Count so that the latched seed equals it.
    task automatic do_draw(input int force_seed, output int card);
        int seed, r, probes, k;
        logic [WIDTH-1:0] cnt;
        if (force_seed >= 0) cnt = WIDTH'(force_seed) ^ m_lfsr[WIDTH-1:0];
        else                 cnt = WIDTH'($urandom);
        bus.i_Count   = cnt;
        bus.i_DrawReq = 1'b1;
        @(negedge clk);
        bus.i_DrawReq = 1'b0;
        chk("busy_start", int'(bus.o_Busy), 1);
        seed = int'(cnt ^ m_prev[WIDTH-1:0]);
        r = seed % NR + 1;
        probes = 1;
        while (m_tally[r] >= CP) begin
            r = (r == NR) ? 1 : r + 1;
            probes++;
        end
        m_tally[r]++;
        m_total++;
        k = 0;
        while (!bus.o_ActCounter && k < 60) begin
            bus.i_Count = WIDTH'($urandom);
            @(negedge clk);
            k++;
        end
        chk("act_latency", k, WIDTH + probes);
        chk("rstc_in_hold", int'(bus.o_RstCounter), 0);
        repeat ($urandom_range(0, 5)) begin
            @(negedge clk);
            chk("no_early_valid", int'(bus.o_CardValid), 0);
        end
        bus.i_TwoSec = 1'b1;
        @(negedge clk);
        bus.i_TwoSec = 1'b0;
        chk("valid_pulse", int'(bus.o_CardValid), 1);
        chk("card", int'(bus.o_Card), r);
        chk("act_off", int'(bus.o_ActCounter), 0);
        chk("rstc_on", int'(bus.o_RstCounter), 1);
        chk("busy_end", int'(bus.o_Busy), 0);
        chk("deck_empty", int'(bus.o_DeckEmpty), (m_total == NR * CP) ? 1 : 0);
        card = int'(bus.o_Card);
        @(negedge clk);
        chk("valid_drop", int'(bus.o_CardValid), 0);
        $display("draw seed=%0d probes=%0d card=%0d total=%0d", seed, probes, card, m_total);
    endtask

    initial begin
        int c;
        bus.i_Count   = '0;
        bus.i_TwoSec  = 1'b0;
        bus.i_DrawReq = 1'b0;
        bus.i_NewDeck = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_card", int'(bus.o_Card), 0);
        chk("rst_valid", int'(bus.o_CardValid), 0);
        chk("rst_busy", int'(bus.o_Busy), 0);
        chk("rst_empty", int'(bus.o_DeckEmpty), 0);
        chk("rst_act", int'(bus.o_ActCounter), 0);
        chk("rst_rstc", int'(bus.o_RstCounter), 1);
        do_reset();

        // Seed 27 -> remainder 1 -> rank 2.
        do_draw(27, c);
        chk("seed27_card", c, 2);

        // Exhaust ranks 5 and 6, then remainder 4 must wrap forward to 7.
        do_reset();
        repeat (4) do_draw(4, c);
        repeat (4) do_draw(5, c);
        do_draw(4, c);
        chk("skip_to_7", c, 7);
        repeat (4) do_draw(12, c);
        do_draw(12, c);
        chk("wrap_to_1", c, 1);

        // Deal out the rest of the deck at random.
        while (m_total < NR * CP) do_draw(-1, c);
        for (int i = 1; i <= NR; i++) chk("tally_full", m_tally[i], CP);
        bus.i_DrawReq = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("empty_ignored_busy", int'(bus.o_Busy), 0);
        end
        bus.i_DrawReq = 1'b0;

        // Refill, deal 10, then NewDeck and DrawReq together: refill wins.
        bus.i_NewDeck = 1'b1;
        @(negedge clk);
        bus.i_NewDeck = 1'b0;
        model_clear();
        chk("refill_empty", int'(bus.o_DeckEmpty), 0);
        repeat (10) do_draw(-1, c);
        bus.i_NewDeck = 1'b1;
        bus.i_DrawReq = 1'b1;
        @(negedge clk);
        bus.i_NewDeck = 1'b0;
        bus.i_DrawReq = 1'b0;
        model_clear();
        chk("newdeck_prio_busy", int'(bus.o_Busy), 0);
        @(negedge clk);
        chk("newdeck_prio_busy2", int'(bus.o_Busy), 0);
        while (m_total < NR * CP) do_draw(-1, c);
        chk("refilled_empty", int'(bus.o_DeckEmpty), 1);

        // Reset while holding the counter: abort, nothing dealt.
        bus.i_NewDeck = 1'b1;
        @(negedge clk);
        bus.i_NewDeck = 1'b0;
        model_clear();
        bus.i_Count   = WIDTH'($urandom);
        bus.i_DrawReq = 1'b1;
        @(negedge clk);
        bus.i_DrawReq = 1'b0;
        c = 0;
        while (!bus.o_ActCounter && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk("abort_reached_hold", int'(bus.o_ActCounter), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_act", int'(bus.o_ActCounter), 0);
        chk("abort_rstc", int'(bus.o_RstCounter), 1);
        chk("abort_busy", int'(bus.o_Busy), 0);
        chk("abort_valid", int'(bus.o_CardValid), 0);
        chk("abort_card", int'(bus.o_Card), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        repeat (6) do_draw(-1, c);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
